// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF sync, polarity fix, debounce FSM, press/release strobes.
// Optional long-press strobe compiled in with BTN_LONG_PRESS_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter bit ACTIVE_LOW        = 1'b0,
  parameter int LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMING    = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] DISARMING = 2'd3;

  // Sync flops reset to the released pin level so reset release is quiet
  localparam logic RELEASED = ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          btn_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign btn_s = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= ARMING;
            cnt   <= '0;
          end
        end
        ARMING: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= DISARMING;
            cnt   <= '0;
          end
        end
        DISARMING: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 2);

  logic [HW-1:0] hold;

  // Hold time spans DISARMING too, so a release bounce keeps the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (state == HELD || state == DISARMING) begin
        if (hold != HOLD_MAX) begin
          hold <= hold + 1'b1;
          if (hold == HOLD_FIRE)
            btn_long <= 1'b1;
        end
      end else begin
        hold <= '0;
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: segment table, corner sequences, random run-length model.
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_btn_conditioner;
  localparam int D = 8;
  localparam int L = 32;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic pin0 = 1'b0;
  logic pin1 = 1'b1;
  logic lvl0, prs0, rel0, lng0;
  logic lvl1, prs1, rel1, lng1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0), .LONG_PRESS_CYCLES(L)
  ) dut0 (
    .clk(clk), .rst(rst0), .btn_in(pin0),
    .btn_level(lvl0), .btn_press(prs0),
    .btn_release(rel0), .btn_long(lng0)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1), .LONG_PRESS_CYCLES(L)
  ) dut1 (
    .clk(clk), .rst(rst1), .btn_in(pin1),
    .btn_level(lvl1), .btn_press(prs1),
    .btn_release(rel1), .btn_long(lng1)
  );

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: the FSM sees the pin two edges late; a level flips after
  // D+1 consecutive sampled edges that disagree with the current level.
  bit m_s1, m_s2, m_lvl, m_press, m_rel, m_long, prev;
  int m_run, m_hold;

  always @(posedge clk or posedge rst0) begin
    if (rst0) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0;
      m_press = 0; m_rel = 0; m_long = 0;
      m_run = 0; m_hold = 0;
    end else begin
      prev = m_lvl;
      m_press = 0; m_rel = 0; m_long = 0;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_s2;
          m_run = 0;
          m_press = m_lvl;
          m_rel = !m_lvl;
        end
      end else begin
        m_run = 0;
      end
`ifdef BTN_LONG_PRESS_EN
      if (prev) begin
        if (m_hold < L) begin
          m_hold++;
          m_long = (m_hold == L - 1);
        end
      end else begin
        m_hold = 0;
      end
`endif
      m_s2 = m_s1;
      m_s1 = pin0;
    end
  end

  always @(negedge clk) begin
    if (!rst0) begin
      tests++;
      if ({lvl0, prs0, rel0, lng0} !== {m_lvl, m_press, m_rel, m_long}) begin
        fails++;
        $display("FAIL model_cmp t=%0t got=%b want=%b", $time,
                 {lvl0, prs0, rel0, lng0}, {m_lvl, m_press, m_rel, m_long});
      end
    end
  end

  typedef struct {
    bit pin;
    int cycles;
    int np;
    int nr;
    bit lvl;
  } seg_t;

  seg_t segs[$];

  initial begin
    int np, nr, nl, lat, lpos, okc;
    seg_t s;

    // glitch train, then bounce-on-release, then debounce boundaries
    for (int k = 0; k < 4; k++) begin
      segs.push_back('{1'b1, 5, 0, 0, 1'b0});
      segs.push_back('{1'b0, 3, 0, 0, 1'b0});
    end
    segs.push_back('{1'b0, 20, 0, 0, 1'b0});
    segs.push_back('{1'b1, 20, 1, 0, 1'b1});
    segs.push_back('{1'b0, 3, 0, 0, 1'b1});
    segs.push_back('{1'b1, 10, 0, 0, 1'b1});
    segs.push_back('{1'b0, 15, 0, 1, 1'b0});
    segs.push_back('{1'b1, 8, 0, 0, 1'b0});
    segs.push_back('{1'b0, 12, 0, 0, 1'b0});
    segs.push_back('{1'b1, 9, 0, 0, 1'b0});
    segs.push_back('{1'b0, 12, 1, 1, 1'b0});
    segs.push_back('{1'b0, 5, 0, 0, 1'b0});

    #1;
    check("rst_out0", int'({lvl0, prs0, rel0, lng0}), 0);
    check("rst_out1", int'({lvl1, prs1, rel1, lng1}), 0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    np = 0;
    repeat (50) begin
      @(negedge clk);
      if (lvl0 | prs0 | rel0 | lng0) np++;
    end
    check("idle_quiet", np, 0);

    // clean press: latency counted in edges after the first sampling edge
    pin0 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (prs0) begin
        lat = i - 1;
        break;
      end
    end
    check("press_latency", lat, D + 2);

    nl = 0; lpos = -1; okc = 0; np = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (lvl0) okc++;
      np += int'(prs0);
      if (lng0) begin
        nl++;
        if (nl == 1) lpos = k;
      end
    end
    check("level_held", okc, 60);
    check("press_single", np, 0);
`ifdef BTN_LONG_PRESS_EN
    check("long_count", nl, 1);
    check("long_pos", lpos, L - 1);
`else
    check("long_off", nl, 0);
`endif

    pin0 = 1'b0;
    nr = 0;
    repeat (20) begin
      @(negedge clk);
      nr += int'(rel0);
    end
    check("release_count", nr, 1);
    check("release_level", int'(lvl0), 0);

    foreach (segs[j]) begin
      s = segs[j];
      pin0 = s.pin;
      np = 0; nr = 0;
      for (int c = 0; c < s.cycles; c++) begin
        @(negedge clk);
        np += int'(prs0);
        nr += int'(rel0);
      end
      check($sformatf("seg%0d_press", j), np, s.np);
      check($sformatf("seg%0d_rel", j), nr, s.nr);
      check($sformatf("seg%0d_lvl", j), int'(lvl0), int'(s.lvl));
    end

    // active-low part: press, reset while held, re-press after reset
    pin1 = 1'b0;
    nr = 0;
    repeat (20) begin
      @(negedge clk);
      nr += int'(rel1);
    end
    check("al_press_level", int'(lvl1), 1);
    rst1 = 1'b1;
    #1;
    check("al_rst_async", int'({lvl1, prs1, rel1}), 0);
    repeat (3) begin
      @(negedge clk);
      nr += int'(rel1);
    end
    rst1 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      nr += int'(rel1);
      if (prs1) begin
        lat = i - 1;
        break;
      end
    end
    check("al_repress_latency", lat, D + 2);
    check("al_no_release", nr, 0);

    // random run lengths, one mid-stream reset; model checks every cycle
    for (int r = 0; r < 80; r++) begin
      pin0 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) @(negedge clk);
      if (r == 40) begin
        rst0 = 1'b1;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
      end
    end
    pin0 = 1'b0;
    repeat (40) @(negedge clk);
    check("final_level", int'(lvl0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
